seq_detect_moore: RTL
=====================

# seq_detect_moore

Parametrised Moore-type serial sequence detector, the successor to the fixed 3-bit "101" detector. It watches a 1-bit serial input qualified by `in_valid` and asserts `out` while the FSM sits in its terminal MATCH state. The pattern is N bits wide and run-time loadable, and overlap or non-overlap matching is selected by parameter. A saturating match counter and the present/next state buses are exposed for debug and waveform inspection.

## Interface
- `N`, 3: pattern length in bits; legal range 2..16.
- `RESET_PATTERN`, 3'b101: pattern register value after reset; width N.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = detection restarts after each match.
- `CNT_W`, 8: match counter width.
- `SW`: derived, $clog2(N+1); state encoding width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `x`  in  1  serial data bit.
- `in_valid`  in  1  `x` is sampled only when high.
- `pat_in`  in  N  new pattern; `pat_in[N-1]` is the first bit expected.
- `pat_load`  in  1  load `pat_in` into the pattern register.
- `cnt_clr`  in  1  synchronous clear of `match_count`.
- `out`  out  1  Moore output; high only while present == N.
- `present`  out  SW  registered current state.
- `next`  out  SW  combinational next state.
- `match_count`  out  CNT_W  saturating count of matches.

## Operation
- States S0..SN. Sk means the last k accepted bits equal the first k pattern bits. SN is MATCH, and `out` = (present == N).
- A history register `hist[N-1:0]` shifts in `x` (LSB = newest) on each accepted bit.
- Next-state rule on an accepted bit: k is the effective current length. k = present, except that k = 0 when present == N and OVERLAP = 0. Next = the largest L in 1..min(k+1, N) such that the newest L bits of {hist, x} equal `pattern[N-1 -: L]`, else S0. This is the KMP longest-suffix-prefix rule. It must hold for every pattern, including all-zeros, all-ones and self-overlapping patterns such as 1111 or 1010.
- `in_valid` low: present, hist and match_count hold. `next` then equals `present`.
- `match_count` increments on each accepted bit whose next state is SN. It saturates at 2^CNT_W-1 and never wraps.
- `pat_load` high: the pattern register takes `pat_in`, present goes to S0, hist clears to 0, and the bit presented that cycle is discarded. match_count is unaffected.
- `cnt_clr` high: match_count goes to 0 on the next edge. If an increment coincides with `cnt_clr`, the clear wins and the count is 0.
- Priority within a cycle: `reset` first, then `pat_load`, then normal `in_valid` processing.

## Timing
- Reset values: present = S0, out = 0, match_count = 0, hist = 0, pattern = RESET_PATTERN. `next` reflects S0 with the live inputs.
- Reset is asynchronous. Asserting it mid-sequence clears all state immediately without waiting for an edge. Detection restarts from S0 on the first accepted bit after deassertion.
- Latency: the final pattern bit is sampled at edge t. `present` = N and `out` = 1 from edge t until the next accepted bit.
- With `in_valid` low after a match, `out` stays high and the match is counted only once.
- `next` is purely combinational from present, hist, pattern, x, in_valid and pat_load. All other outputs are registered.
- N = 2..16 gives SW = 2..5. No arithmetic overflow is permitted anywhere except the explicit saturation of match_count.

## Test plan
- Default (N=3, 101, OVERLAP=1). Stream 1,0,1,0,1 with valid every cycle -> out high for one cycle after the 3rd and 5th bits; match_count = 2; present sequence S1,S2,S3,S2,S3.
- OVERLAP=0, same stream -> out high only after the 3rd bit; count = 1. Stream 1,0,1,1,0,1 -> count = 2.
- N=4, load 1101 via `pat_load`, then stream 1,1,1,0,1,1,0,1 -> matches after bits 5 and 8; the 1,1,1 prefix holds present at S2.
- `in_valid` toggling: deassert `in_valid` for 3 cycles between the bits of 101 -> match still detected; state frozen while invalid; count = 1.
- Assert `reset` asynchronously between edges while in S2 -> present = S0 and out = 0 before the next edge; a following 0,1 does not match.
- CNT_W=2 with OVERLAP=1 and pattern 11, streaming six 1s -> count saturates at 3. Then `cnt_clr` asserted together with a match -> count = 0.

Source files
------------

// File: rtl/seq_detect_moore.sv
// Parametrised Moore sequence detector with a run-time loadable N-bit pattern,
// KMP-style longest suffix/prefix next state, and a saturating match counter.
module seq_detect_moore #(
  parameter int           N             = 3,
  parameter logic [N-1:0] RESET_PATTERN = N'(3'b101),
  parameter bit           OVERLAP       = 1'b1,
  parameter int           CNT_W         = 8,
  parameter int           SW            = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             in_valid,
  input  logic [N-1:0]     pat_in,
  input  logic             pat_load,
  input  logic             cnt_clr,
  output logic             out,
  output logic [SW-1:0]    present,
  output logic [SW-1:0]    next,
  output logic [CNT_W-1:0] match_count
);

  logic [N-1:0]  pattern;
  logic [N-1:0]  hist;
  logic [SW-1:0] k;
  logic [N:0]    win, m, pw;
  logic          hit;

  // Try every prefix length; ascending order lets the longest legal match win.
  always_comb begin
    next = present;
    k    = (present == SW'(N) && !OVERLAP) ? '0 : present;
    win  = {hist, x};
    m    = '0;
    pw   = '0;
    if (pat_load) begin
      next = '0;
    end else if (in_valid) begin
      next = '0;
      for (int l = 1; l <= N; l++) begin
        m  = {(N+1){1'b1}} >> (N + 1 - l);
        pw = {1'b0, pattern} >> (N - l);
        if (l <= int'(k) + 1 && (win & m) == pw) next = SW'(l);
      end
    end
  end

  assign hit = in_valid && !pat_load && (next == SW'(N));
  assign out = (present == SW'(N));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      present <= '0;
      hist    <= '0;
      pattern <= RESET_PATTERN;
    end else if (pat_load) begin
      pattern <= pat_in;
      present <= '0;
      hist    <= '0;
    end else if (in_valid) begin
      present <= next;
      hist    <= {hist[N-2:0], x};
    end
  end

  // Clear beats a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      match_count <= '0;
    else if (cnt_clr)
      match_count <= '0;
    else if (hit && match_count != '1)
      match_count <= match_count + 1'b1;
  end

endmodule
